mm_bram_sequencer: RTL and testbench

Sequencer placed between the operand/result Block RAM and the FIOS Montgomery multiplier core (cascaded or non-cascaded variant) inside the MM demo IP. On `start_i` it fetches p'_0, p, a and b from BRAM into parallel operand registers, pulses the core start, and waits for core done. It then writes the s-limb result back to BRAM and raises `done_o`. It also counts core busy cycles for latency measurement.

---
 rtl/mm_bram_sequencer_if.sv | 37 +++
 rtl/mm_bram_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mm_bram_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_bram_sequencer_if.sv
// Operand/result BRAM port plus FIOS core handshake of the MM BRAM sequencer.
// slave is the sequencer itself; master is the BRAM/core/controller side.
interface mm_bram_sequencer_if #(
  parameter int WIDTH = 256
);
  localparam int S  = (WIDTH + 1) / 17 + 1;
  localparam int LW = 17 * S;

  logic          start_i;
  logic          done_o;
  logic          busy_o;
  logic [31:0]   bram_addr_o;
  logic          bram_en_o;
  logic [3:0]    bram_we_o;
  logic [31:0]   bram_din_o;
  logic [31:0]   bram_dout_i;
  logic [16:0]   p_prime_0_o;
  logic [LW-1:0] p_o;
  logic [LW-1:0] a_o;
  logic [LW-1:0] b_o;
  logic          fios_start_o;
  logic          fios_done_i;
  logic [LW-1:0] fios_res_i;
  logic [31:0]   cycle_count_o;

  modport slave (
    input  start_i, bram_dout_i, fios_done_i, fios_res_i,
    output done_o, busy_o, bram_addr_o, bram_en_o, bram_we_o, bram_din_o,
           p_prime_0_o, p_o, a_o, b_o, fios_start_o, cycle_count_o
  );

  modport master (
    output start_i, bram_dout_i, fios_done_i, fios_res_i,
    input  done_o, busy_o, bram_addr_o, bram_en_o, bram_we_o, bram_din_o,
           p_prime_0_o, p_o, a_o, b_o, fios_start_o, cycle_count_o
  );
endinterface

// File: rtl/mm_bram_sequencer.sv
// Fetches p'_0/p/a/b from BRAM into operand registers, runs the FIOS core once,
// writes the s-limb result back to BRAM words 0..s-1 and times the core.
//
//   state | meaning
//   IDLE  | after reset, waiting for start_i
//   LOAD  | issuing BRAM reads 0..3s and capturing the returned words
//   START | one-cycle core start pulse, busy counter cleared
//   WAIT  | counting core busy cycles until fios_done_i
//   STORE | writing result limb i to word i, one per cycle
//   DONE  | done_o high, operands and count held until next start_i
module mm_bram_sequencer #(
  parameter int WIDTH  = 256,
  parameter int RD_LAT = 2
) (
  input logic                clock_i,
  input logic                reset_i,
  mm_bram_sequencer_if.slave bus
);
  localparam int S  = (WIDTH + 1) / 17 + 1;
  localparam int LW = 17 * S;
  localparam int CW = $clog2(3 * S + RD_LAT + 1);
  localparam int SW = $clog2(S + 1);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(3 * S + RD_LAT);
  localparam logic [CW-1:0] ISSUE_LAST = CW'(3 * S);
  localparam logic [SW-1:0] STORE_LAST = SW'(S - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, STORE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] load_cnt;
  logic [SW-1:0] st_idx;
  logic [LW-1:0] res_r, p_r, a_r, b_r;
  logic [16:0]   pp0_r;
  logic          done_r, busy_r, fs_r, en_r;
  logic [3:0]    we_r;
  logic [31:0]   addr_r, din_r, cnt_r;

  logic [CW-1:0] load_next;
  logic [SW-1:0] st_next;
  logic [16:0]   st_limb;
  logic [16:0]   rd_limb;
  logic [1:0]    cap_grp;
  int            cap_j;
  int            cap_l;
  logic          unused_dout_hi;

  assign rd_limb        = bus.bram_dout_i[16:0];
  assign unused_dout_hi = ^bus.bram_dout_i[31:17];

  // Word j returned by the BRAM belongs to p'_0 (j=0), else p/a/b limb (j-1) mod s.
  always_comb begin
    load_next = load_cnt + CW'(1);
    st_next   = st_idx + SW'(1);
    cap_j     = int'(load_cnt) - RD_LAT;
    cap_grp   = 2'd0;
    cap_l     = 0;
    if (cap_j >= 1 + 2 * S) begin
      cap_grp = 2'd3;
      cap_l   = cap_j - 1 - 2 * S;
    end else if (cap_j >= 1 + S) begin
      cap_grp = 2'd2;
      cap_l   = cap_j - 1 - S;
    end else if (cap_j >= 1) begin
      cap_grp = 2'd1;
      cap_l   = cap_j - 1;
    end
    st_limb = '0;
    for (int i = 0; i < S; i++) begin
      if (int'(st_next) == i) st_limb = res_r[17*i +: 17];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      load_cnt <= '0;
      st_idx   <= '0;
      res_r    <= '0;
      p_r      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      pp0_r    <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      fs_r     <= 1'b0;
      en_r     <= 1'b0;
      we_r     <= 4'h0;
      addr_r   <= '0;
      din_r    <= '0;
      cnt_r    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start_i) begin
            state    <= LOAD;
            done_r   <= 1'b0;
            busy_r   <= 1'b1;
            en_r     <= 1'b1;
            we_r     <= 4'h0;
            addr_r   <= '0;
            load_cnt <= '0;
          end
        end
        LOAD: begin
          if (cap_j >= 0) begin
            for (int i = 0; i < S; i++) begin
              if (cap_l == i) begin
                case (cap_grp)
                  2'd1:    p_r[17*i +: 17] <= rd_limb;
                  2'd2:    a_r[17*i +: 17] <= rd_limb;
                  2'd3:    b_r[17*i +: 17] <= rd_limb;
                  default: ;
                endcase
              end
            end
            if (cap_grp == 2'd0) pp0_r <= rd_limb;
          end
          load_cnt <= load_next;
          if (load_cnt < ISSUE_LAST) begin
            en_r   <= 1'b1;
            addr_r <= 32'(load_next) << 2;
          end else begin
            en_r   <= 1'b0;
            addr_r <= '0;
          end
          if (load_cnt == LOAD_LAST) begin
            state <= START;
            fs_r  <= 1'b1;
          end
        end
        START: begin
          fs_r  <= 1'b0;
          cnt_r <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.fios_done_i) begin
            res_r  <= bus.fios_res_i;
            state  <= STORE;
            st_idx <= '0;
            en_r   <= 1'b1;
            we_r   <= 4'hf;
            addr_r <= '0;
            din_r  <= {15'b0, bus.fios_res_i[16:0]};
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        STORE: begin
          if (st_idx == STORE_LAST) begin
            state  <= DONE;
            en_r   <= 1'b0;
            we_r   <= 4'h0;
            addr_r <= '0;
            din_r  <= '0;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end else begin
            st_idx <= st_next;
            addr_r <= 32'(st_next) << 2;
            din_r  <= {15'b0, st_limb};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done_o        = done_r;
  assign bus.busy_o        = busy_r;
  assign bus.bram_addr_o   = addr_r;
  assign bus.bram_en_o     = en_r;
  assign bus.bram_we_o     = we_r;
  assign bus.bram_din_o    = din_r;
  assign bus.p_prime_0_o   = pp0_r;
  assign bus.p_o           = p_r;
  assign bus.a_o           = a_r;
  assign bus.b_o           = b_r;
  assign bus.fios_start_o  = fs_r;
  assign bus.cycle_count_o = cnt_r;
endmodule

// File: tb/tb_mm_bram_sequencer.sv
// Bench for mm_bram_sequencer: two instances (RD_LAT=2 and RD_LAT=1) share stimulus,
// each with its own BRAM model; results are compared against a word-map model.
`timescale 1ns/1ps
module tb_mm_bram_sequencer;
  localparam int WIDTH = 256;
  localparam int S     = (WIDTH + 1) / 17 + 1;
  localparam int LW    = 17 * S;
  localparam int NW    = 64;

  typedef struct {
    int delay;
    bit rnd;
    int base;
    bit inj;
    int exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic fdone = 1'b0;
  logic [LW-1:0] fres = '0;
  logic do_init = 1'b0;
  logic [31:0] init_mem [NW];
  logic [31:0] mem_a [NW];
  logic [31:0] mem_b [NW];
  logic [31:0] q_a = '0, dout_a = '0, dout_b = '0;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int fs_cnt_a = 0, fs_cnt_b = 0, wr_cnt_a = 0, wr_cnt_b = 0;
  int fs_cyc_b = 0, dn_cyc_b = 0;
  logic prev_done_b = 1'b0;
  int n0 = 0;

  always #5 clk = ~clk;

  mm_bram_sequencer_if #(.WIDTH(WIDTH)) bus_a ();
  mm_bram_sequencer_if #(.WIDTH(WIDTH)) bus_b ();

  mm_bram_sequencer #(.WIDTH(WIDTH), .RD_LAT(2)) dut_a (.clock_i(clk), .reset_i(rst), .bus(bus_a));
  mm_bram_sequencer #(.WIDTH(WIDTH), .RD_LAT(1)) dut_b (.clock_i(clk), .reset_i(rst), .bus(bus_b));

  assign bus_a.start_i     = start;
  assign bus_a.fios_done_i = fdone;
  assign bus_a.fios_res_i  = fres;
  assign bus_a.bram_dout_i = dout_a;
  assign bus_b.start_i     = start;
  assign bus_b.fios_done_i = fdone;
  assign bus_b.fios_res_i  = fres;
  assign bus_b.bram_dout_i = dout_b;

  // BRAM models: two-stage read pipe for instance a, one-stage for b
  always @(posedge clk) begin
    if (do_init) begin
      mem_a <= init_mem;
      mem_b <= init_mem;
    end else begin
      if (bus_a.bram_en_o && bus_a.bram_we_o == 4'hf) mem_a[bus_a.bram_addr_o[7:2]] <= bus_a.bram_din_o;
      if (bus_b.bram_en_o && bus_b.bram_we_o == 4'hf) mem_b[bus_b.bram_addr_o[7:2]] <= bus_b.bram_din_o;
    end
    if (bus_a.bram_en_o) q_a <= mem_a[bus_a.bram_addr_o[7:2]];
    dout_a <= q_a;
    if (bus_b.bram_en_o) dout_b <= mem_b[bus_b.bram_addr_o[7:2]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_a.fios_start_o) fs_cnt_a <= fs_cnt_a + 1;
    if (bus_b.fios_start_o) begin
      fs_cnt_b <= fs_cnt_b + 1;
      fs_cyc_b <= cyc;
    end
    if (bus_a.bram_en_o && bus_a.bram_we_o != 4'h0) wr_cnt_a <= wr_cnt_a + 1;
    if (bus_b.bram_en_o && bus_b.bram_we_o != 4'h0) wr_cnt_b <= wr_cnt_b + 1;
    if (bus_b.done_o && !prev_done_b) dn_cyc_b <= cyc;
    prev_done_b <= bus_b.done_o;
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event never seen within the cycle budget", name);
  endtask

  function automatic logic [LW-1:0] exp_group(input int g);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < S; i++) v[17*i +: 17] = init_mem[1 + g * S + i][16:0];
    return v;
  endfunction

  task automatic wait_fs_a(input string name, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (bus_a.fios_start_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_done_a(input string name, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (bus_a.done_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout(name);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n0 = cyc;
  endtask

  task automatic run_job(input vec_t v);
    logic [16:0] res_w [S];
    logic [31:0] exp_w;
    int fs0_a, fs0_b, wr0_a, wr0_b, ed;
    bit ok;
    for (int k = 0; k < NW; k++) init_mem[k] = v.rnd ? 32'($urandom) : 32'(v.base + k);
    for (int i = 0; i < S; i++) res_w[i] = v.rnd ? 17'($urandom) : 17'(i + 1);
    for (int i = 0; i < S; i++) fres[17*i +: 17] = res_w[i];
    @(negedge clk);
    do_init = 1'b1;
    @(negedge clk);
    do_init = 1'b0;
    fs0_a = fs_cnt_a;
    fs0_b = fs_cnt_b;
    wr0_a = wr_cnt_a;
    wr0_b = wr_cnt_b;
    pulse_start();
    if (v.inj) begin
      repeat (4) @(negedge clk);
      fdone = 1'b1;
      @(negedge clk);
      fdone = 1'b0;
    end
    wait_fs_a("fs_wait", ok);
    if (!ok) return;
    chk("fs_cycle_a", cyc - n0 + 1, 3 * S + 2 + 2);
    for (int d = 1; d <= v.delay; d++) begin
      @(negedge clk);
      start = v.inj && d == 1;
      fdone = (d == v.delay);
    end
    ed = cyc - n0 + 1;
    @(negedge clk);
    fdone = 1'b0;
    start = 1'b0;
    wait_done_a("done_wait", ok);
    if (!ok) return;
    chk("done_cycle_a", cyc - n0 + 1, ed + S + 1);
    @(negedge clk);
    chk("fs_cycle_b", fs_cyc_b - n0 + 1, 3 * S + 2 + 1);
    chk("done_cycle_b", dn_cyc_b - n0 + 1, ed + S + 1);
    chk("fs_pulses_a", fs_cnt_a - fs0_a, 1);
    chk("fs_pulses_b", fs_cnt_b - fs0_b, 1);
    chk("writes_a", wr_cnt_a - wr0_a, S);
    chk("writes_b", wr_cnt_b - wr0_b, S);
    chk("count_a", bus_a.cycle_count_o, v.exp_cnt);
    chk("count_b", bus_b.cycle_count_o, v.exp_cnt + 1);
    chk("pp0_a", bus_a.p_prime_0_o, init_mem[0][16:0]);
    chk("pp0_b", bus_b.p_prime_0_o, init_mem[0][16:0]);
    chk("p_a", bus_a.p_o, exp_group(0));
    chk("a_a", bus_a.a_o, exp_group(1));
    chk("b_a", bus_a.b_o, exp_group(2));
    chk("p_b", bus_b.p_o, exp_group(0));
    chk("a_b", bus_b.a_o, exp_group(1));
    chk("b_b", bus_b.b_o, exp_group(2));
    for (int k = 0; k < NW; k++) begin
      exp_w = (k < S) ? {15'b0, res_w[k]} : init_mem[k];
      chk($sformatf("mem_a[%0d]", k), mem_a[k], exp_w);
      chk($sformatf("mem_b[%0d]", k), mem_b[k], exp_w);
    end
    repeat (5) @(negedge clk);
    chk("done_hold_a", bus_a.done_o, 1'b1);
    chk("done_hold_b", bus_b.done_o, 1'b1);
    chk("idle_bus_a", {bus_a.busy_o, bus_a.bram_en_o, bus_a.bram_we_o}, '0);
    chk("idle_bus_b", {bus_b.busy_o, bus_b.bram_en_o, bus_b.bram_we_o}, '0);
  endtask

  function automatic logic any_out_a();
    return |{bus_a.done_o, bus_a.busy_o, bus_a.fios_start_o, bus_a.bram_en_o, bus_a.bram_we_o,
             bus_a.bram_addr_o, bus_a.bram_din_o, bus_a.p_prime_0_o, bus_a.p_o, bus_a.a_o,
             bus_a.b_o, bus_a.cycle_count_o};
  endfunction

  function automatic logic any_out_b();
    return |{bus_b.done_o, bus_b.busy_o, bus_b.fios_start_o, bus_b.bram_en_o, bus_b.bram_we_o,
             bus_b.bram_addr_o, bus_b.bram_din_o, bus_b.p_prime_0_o, bus_b.p_o, bus_b.a_o,
             bus_b.b_o, bus_b.cycle_count_o};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t rv;
    int wr0_a, wr0_b, fs0_a, fs0_b;
    bit ok;

    vecs[0] = '{200, 1'b0, 'h100,   1'b0, 199};
    vecs[1] = '{1,   1'b1, 0,       1'b1, 0};
    vecs[2] = '{2,   1'b0, 'h1f000, 1'b0, 1};
    vecs[3] = '{37,  1'b1, 0,       1'b1, 36};
    vecs[4] = '{5,   1'b1, 0,       1'b0, 4};
    for (int k = 0; k < NW; k++) init_mem[k] = '0;

    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state_a", any_out_a(), 1'b0);
    chk("reset_state_b", any_out_b(), 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i]);
      if (i == 0) begin
        chk("map_pp0", bus_a.p_prime_0_o, 17'h100);
        chk("map_p0", bus_a.p_o[16:0], 17'h101);
        chk("map_a0", bus_a.a_o[16:0], 17'h111);
        chk("map_b15", bus_a.b_o[17*15 +: 17], 17'h130);
        chk("map_b15_rl1", bus_b.b_o[17*15 +: 17], 17'h130);
      end
    end

    for (int r = 0; r < 5; r++) begin
      rv.delay   = int'($urandom_range(1, 60));
      rv.rnd     = 1'b1;
      rv.base    = 0;
      rv.inj     = bit'($urandom_range(0, 1));
      rv.exp_cnt = rv.delay - 1;
      run_job(rv);
    end

    // asynchronous reset in the middle of LOAD
    pulse_start();
    repeat (20) @(negedge clk);
    chk("midload_busy_a", bus_a.busy_o, 1'b1);
    chk("midload_en_b", bus_b.bram_en_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_a", any_out_a(), 1'b0);
    chk("rst_async_b", any_out_b(), 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wr0_a = wr_cnt_a;
    wr0_b = wr_cnt_b;
    fs0_a = fs_cnt_a;
    fs0_b = fs_cnt_b;
    repeat (10) @(negedge clk);
    chk("rst_nowrite_a", wr_cnt_a - wr0_a, 0);
    chk("rst_nowrite_b", wr_cnt_b - wr0_b, 0);
    chk("rst_nostart", (fs_cnt_a - fs0_a) + (fs_cnt_b - fs0_b), 0);
    chk("rst_idle_a", {bus_a.busy_o, bus_a.done_o}, '0);
    chk("rst_idle_b", {bus_b.busy_o, bus_b.done_o}, '0);

    // start_i held high: done_o is a one-cycle pulse and the next job starts at once
    @(negedge clk);
    start = 1'b1;
    wait_fs_a("held_fs1", ok);
    repeat (3) @(negedge clk);
    fdone = 1'b1;
    @(negedge clk);
    fdone = 1'b0;
    wait_done_a("held_done1", ok);
    chk("held_done_a", bus_a.done_o, 1'b1);
    chk("held_done_b", bus_b.done_o, 1'b1);
    @(negedge clk);
    chk("held_pulse_a", {bus_a.done_o, bus_a.busy_o}, 2'b01);
    chk("held_pulse_b", {bus_b.done_o, bus_b.busy_o}, 2'b01);
    start = 1'b0;
    wait_fs_a("held_fs2", ok);
    @(negedge clk);
    fdone = 1'b1;
    @(negedge clk);
    fdone = 1'b0;
    wait_done_a("held_done2", ok);
    repeat (4) @(negedge clk);
    chk("held_end_a", {bus_a.done_o, bus_a.busy_o}, 2'b10);
    chk("held_end_b", {bus_b.done_o, bus_b.busy_o}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
